// File: rtl/rv32i_data_memory_if.sv
// rtl/rv32i_data_memory_if.sv - memory-stage load/store bus between core and data memory
interface rv32i_data_memory_if;
    logic        MemRW;
    logic [31:0] Addr;
    logic [31:0] DataW;
    logic [2:0]  mem_type;
    logic [31:0] DataR;

    modport master (
        output MemRW,
        output Addr,
        output DataW,
        output mem_type,
        input  DataR
    );

    modport slave (
        input  MemRW,
        input  Addr,
        input  DataW,
        input  mem_type,
        output DataR
    );
endinterface

// File: rtl/rv32i_data_memory.sv
// rtl/rv32i_data_memory.sv - RV32I byte-addressed data memory, combinational load, lane-masked store
module rv32i_data_memory #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input logic                 clk,
    input logic                 rst,
    rv32i_data_memory_if.slave  bus
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    logic [AWIDTH-1:0] idx;
    logic [1:0]        lane;
    logic [3:0]        wmask;
    logic [31:0]       wdata;
    logic [31:0]       rword;
    logic [31:0]       rshift;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic              unused_addr;

    assign idx         = bus.Addr[AWIDTH+1:2];
    assign lane        = bus.Addr[1:0];
    assign unused_addr = ^bus.Addr[31:AWIDTH+2];

    // Store data is replicated across lanes so the mask alone picks the destination.
    always_comb begin
        wmask = 4'b0000;
        wdata = 32'h0;
        case (bus.mem_type)
            3'd0: begin
                wmask = 4'b0001 << lane;
                wdata = {4{bus.DataW[7:0]}};
            end
            3'd1: begin
                wmask = bus.Addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.DataW[15:0]}};
            end
            3'd2: begin
                wmask = 4'b1111;
                wdata = bus.DataW;
            end
            default: begin
                wmask = 4'b0000;
                wdata = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (bus.MemRW) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rword  = mem[idx];
    assign rshift = rword >> {lane, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = bus.Addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        bus.DataR = 32'h0;
        case (bus.mem_type)
            3'd0:    bus.DataR = {{24{rbyte[7]}}, rbyte};
            3'd1:    bus.DataR = {{16{rhalf[15]}}, rhalf};
            3'd2:    bus.DataR = rword;
            3'd4:    bus.DataR = {24'h0, rbyte};
            3'd5:    bus.DataR = {16'h0, rhalf};
            default: bus.DataR = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_rv32i_data_memory.sv
// tb/tb_rv32i_data_memory.sv - scoreboard bench for rv32i_data_memory
module tb_rv32i_data_memory;

    logic clk;
    logic rst;
    rv32i_data_memory_if bus ();

    rv32i_data_memory #(.DWIDTH(32), .AWIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  t;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    logic check_req;
    int   vectors;
    int   miscompares;
    logic stim_done;

    // Monitor: one expected entry is consumed per sampled read request.
    always @(negedge clk) begin
        if (check_req) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: DataR=%08h with no expected entry", bus.DataR);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.DataR !== e.exp) begin
                    miscompares++;
                    $display("FAIL load addr=%08h type=%0d: got %08h expected %08h",
                             e.addr, e.t, bus.DataR, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        check_req    = 1'b0;
        bus.MemRW    = 1'b1;
        bus.Addr     = a;
        bus.DataW    = d;
        bus.mem_type = t;
        tick();
        bus.MemRW    = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] e);
        exp_t x;
        bus.MemRW    = 1'b0;
        bus.Addr     = a;
        bus.mem_type = t;
        x.addr = a; x.t = t; x.exp = e;
        exp_q.push_back(x);
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; stim_done = 1'b0;
        check_req = 1'b0;
        rst = 1'b0;
        bus.MemRW = 1'b0; bus.Addr = '0; bus.DataW = '0; bus.mem_type = 3'd2;
        tick(); tick();
        rst = 1'b1;

        // Reset clear after nonzero data
        store(32'd0, 32'hDEADBEEF, 3'd2);
        store(32'd4, 32'hCAFEF00D, 3'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int a = 0; a < 6; a++)
            for (int t = 0; t < 8; t++)
                load(a, t[2:0], 32'h0);

        // Word store/load over the full array, plus wrap
        for (int i = 0; i < 1024; i++) store(4*i, i, 3'd2);
        for (int i = 0; i < 1024; i++) load(4*i, 3'd2, i);
        load(32'd4096, 3'd2, 32'd0);
        load(32'd4100, 3'd2, 32'd1);
        load(32'hFFFF_FFFC, 3'd2, 32'd1023);

        // Byte and halfword sign handling
        store(32'd0, 32'h80FF7F01, 3'd2);
        load(32'd0, 3'd0, 32'h00000001);
        load(32'd1, 3'd0, 32'h0000007F);
        load(32'd2, 3'd0, 32'hFFFFFFFF);
        load(32'd3, 3'd0, 32'hFFFFFF80);
        load(32'd0, 3'd4, 32'h00000001);
        load(32'd1, 3'd4, 32'h0000007F);
        load(32'd2, 3'd4, 32'h000000FF);
        load(32'd3, 3'd4, 32'h00000080);
        load(32'd0, 3'd1, 32'h00007F01);
        load(32'd1, 3'd1, 32'h00007F01);
        load(32'd2, 3'd1, 32'hFFFF80FF);
        load(32'd3, 3'd1, 32'hFFFF80FF);
        load(32'd2, 3'd5, 32'h000080FF);
        load(32'd0, 3'd5, 32'h00007F01);
        load(32'd3, 3'd2, 32'h80FF7F01);

        // Partial stores
        store(32'd8, 32'h11223344, 3'd2);
        store(32'd9, 32'h123456AA, 3'd0);
        load(32'd8, 3'd2, 32'h1122AA44);
        store(32'd10, 32'hCAFEBEEF, 3'd1);
        load(32'd8, 3'd2, 32'hBEEFAA44);
        store(32'd8, 32'hFFFFFFFF, 3'd3);
        store(32'd8, 32'hFFFFFFFF, 3'd6);
        store(32'd8, 32'hFFFFFFFF, 3'd7);
        load(32'd8, 3'd2, 32'hBEEFAA44);
        store(32'd11, 32'h00000012, 3'd0);
        load(32'd8, 3'd2, 32'h12EFAA44);
        store(32'd9, 32'h00005566, 3'd1);
        load(32'd8, 3'd2, 32'h12EF5566);

        // Illegal load codes
        load(32'd8, 3'd3, 32'h0);
        load(32'd8, 3'd6, 32'h0);
        load(32'd8, 3'd7, 32'h0);

        // Read-during-write returns old data until the edge
        begin
            exp_t x;
            bus.MemRW = 1'b1; bus.Addr = 32'd16; bus.DataW = 32'h00000099; bus.mem_type = 3'd2;
            x.addr = 32'd16; x.t = 3'd2; x.exp = 32'd4;
            exp_q.push_back(x);
            check_req = 1'b1;
            tick();
            check_req = 1'b0;
            bus.MemRW = 1'b0;
        end
        load(32'd16, 3'd2, 32'h00000099);

        // Reset beats a store in the same cycle
        rst = 1'b0;
        bus.MemRW = 1'b1; bus.Addr = 32'd12; bus.DataW = 32'h55555555; bus.mem_type = 3'd2;
        tick();
        bus.MemRW = 1'b0;
        rst = 1'b1;
        load(32'd12, 3'd2, 32'h0);
        load(32'd8, 3'd2, 32'h0);
        load(32'd4092, 3'd2, 32'h0);

        tick();
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        if (!stim_done) begin
            $display("FAIL watchdog: stimulus did not finish, vectors=%0d", vectors);
            $fatal(1, "watchdog expired");
        end
    end

endmodule
